// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word fetch over a req/ack port into a
// prefetch queue of {pc, instr}, with flush/re-steer on redirect.
module fetch_unit #(
    parameter logic [31:0] INIT_PC = 32'h10000000,
    parameter int          DEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = DEPTH[PW:0];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef enum logic {RUN, DISCARD} state_t;

    entry_t        q_mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic [31:0]   fetch_pc, req_addr;
    logic          busy;
    state_t        state, state_nxt;
    logic          ack, push, pop, can_start;

    assign can_start = (count < FULL);
    assign ack       = i_imem_ack && o_imem_req;
    assign push      = ack && (state == RUN) && !i_redirect;
    assign pop       = o_valid && i_ready && !i_redirect;

    assign o_valid = !i_rst && (count != '0);
    assign o_pc    = q_mem[rd_ptr].pc;
    assign o_instr = q_mem[rd_ptr].instr;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= RUN;
        else       state <= state_nxt;
    end

    // Next state: a redirect that finds an un-acked request in flight must
    // wait out that stale response before fetching from the new PC.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (i_redirect && o_imem_req && !i_imem_ack) state_nxt = DISCARD;
            DISCARD: if (i_imem_ack) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Outputs: request is driven from registered state only (busy, count);
    // a held request keeps its captured address.
    always_comb begin
        o_imem_req  = !i_rst && (busy || (state == DISCARD) || can_start);
        o_imem_addr = busy ? req_addr : fetch_pc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc <= INIT_PC & ~32'h3;
            req_addr <= INIT_PC & ~32'h3;
            busy     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            busy     <= o_imem_req && !i_imem_ack;
            req_addr <= o_imem_addr;
            if (i_redirect) begin
                fetch_pc <= i_redirect_pc & ~32'h3;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    wr_ptr   <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage carries no reset; count gates visibility.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) q_mem[wr_ptr] <= '{pc: o_imem_addr, instr: i_imem_data};
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus a randomized run
// checked against an instruction-stream model and handshake rules.
module tb_fetch_unit;
    localparam logic [31:0] INIT = 32'h10000000;
    localparam logic [31:0] KEY  = 32'hA5A5A5A5;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_data = '0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    // memory model controls
    int lat = 0;
    bit rand_lat = 0;
    bit stray_en = 0;
    bit req_active = 0;
    int wcnt = 0;
    int ack_cnt = 0;

    fetch_unit #(.INIT_PC(INIT), .DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc),
        .i_ready(i_ready)
    );

    always #5 i_clk = ~i_clk;

    // Memory: acks a request in its lat-th cycle (0 = same cycle), returns addr^KEY.
    always @(negedge i_clk) begin
        #2;
        if (i_rst || !o_imem_req) begin
            req_active = 0;
            i_imem_ack = stray_en && !i_rst && ($urandom_range(0, 3) == 0);
            i_imem_data = $urandom;
        end else begin
            if (!req_active) begin
                req_active = 1;
                wcnt = 0;
                if (rand_lat) lat = $urandom_range(0, 3);
            end else wcnt++;
            if (wcnt >= lat) begin
                i_imem_ack = 1'b1;
                i_imem_data = o_imem_addr ^ KEY;
                req_active = 0;
                ack_cnt++;
            end else begin
                i_imem_ack = 1'b0;
                i_imem_data = $urandom;
            end
        end
    end

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_redirect = 1'b0;
        @(negedge i_clk);
        ack_cnt = 0;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_ready = 1'b1; lat = 0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_outputs valid=%b req=%b want 0/0", o_valid, o_imem_req);
        end
        @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] a;
        i_ready = 1'b1; lat = 0; rand_lat = 0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            a = INIT + 32'(4 * k);
            checks++;
            if (o_imem_req !== 1'b1 || o_imem_addr !== a) begin
                errors++; $display("FAIL stream_req cyc%0d req=%b addr=%h want 1/%h", k, o_imem_req, o_imem_addr, a);
            end
            if (k >= 1) begin
                a = INIT + 32'(4 * (k - 1));
                checks++;
                if (o_valid !== 1'b1 || o_pc !== a || o_instr !== (a ^ KEY)) begin
                    errors++; $display("FAIL stream_out cyc%0d valid=%b pc=%h instr=%h want pc %h", k, o_valid, o_pc, o_instr, a);
                end
            end else begin
                checks++;
                if (o_valid !== 1'b0) begin
                    errors++; $display("FAIL stream_cyc0_valid got %b want 0", o_valid);
                end
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] a;
        i_ready = 1'b0; lat = 0;
        do_reset();
        repeat (8) @(negedge i_clk);
        checks++;
        if (ack_cnt !== 4 || o_imem_req !== 1'b0) begin
            errors++; $display("FAIL full_stop acks=%0d req=%b want 4/0", ack_cnt, o_imem_req);
        end
        checks++;
        if (o_valid !== 1'b1 || o_pc !== INIT) begin
            errors++; $display("FAIL full_head valid=%b pc=%h want 1/%h", o_valid, o_pc, INIT);
        end
        i_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge i_clk);
            a = INIT + 32'(4 * j);
            if (j == 1) begin
                checks++;
                if (o_imem_req !== 1'b1 || o_imem_addr !== INIT + 32'h10) begin
                    errors++; $display("FAIL full_resume req=%b addr=%h want 1/%h", o_imem_req, o_imem_addr, INIT + 32'h10);
                end
            end
            checks++;
            if (o_valid !== 1'b1 || o_pc !== a || o_instr !== (a ^ KEY)) begin
                errors++; $display("FAIL full_drain j=%0d pc=%h instr=%h want %h", j, o_pc, o_instr, a);
            end
        end
    endtask

    // Redirect(s) while the first request waits; stale word must never surface.
    task automatic test_redirect_discard(input bit twice);
        logic [31:0] want;
        bit seen;
        want = 32'h10000200;
        i_ready = 1'b1; lat = 3;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            i_redirect = 1'b0;
            if (c == 1) begin
                i_redirect = 1'b1;
                i_redirect_pc = twice ? 32'h10000100 : 32'h10000203;
            end
            if (c == 2 && twice) begin
                i_redirect = 1'b1;
                i_redirect_pc = 32'h10000200;
            end
            checks++;
            if (c <= 3 && (o_imem_req !== 1'b1 || o_imem_addr !== INIT)) begin
                errors++; $display("FAIL disc_hold c=%0d req=%b addr=%h want 1/%h", c, o_imem_req, o_imem_addr, INIT);
            end
            if (c == 4 && (o_imem_req !== 1'b1 || o_imem_addr !== want)) begin
                errors++; $display("FAIL disc_newreq req=%b addr=%h want 1/%h", o_imem_req, o_imem_addr, want);
            end
            checks++;
            if (o_valid !== 1'b0) begin
                errors++; $display("FAIL disc_novalid c=%0d valid=%b pc=%h want 0", c, o_valid, o_pc);
            end
        end
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || o_pc !== want || o_instr !== (want ^ KEY)) begin
            errors++; $display("FAIL disc_first seen=%0d pc=%h instr=%h want %h", seen, o_pc, o_instr, want);
        end
    endtask

    task automatic test_redirect_ack_pop();
        logic [31:0] r;
        r = 32'h10000400;
        i_ready = 1'b1; lat = 0;
        do_reset();
        repeat (4) @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_imem_req !== 1'b1) begin
            errors++; $display("FAIL rap_pre valid=%b req=%b want 1/1", o_valid, o_imem_req);
        end
        i_redirect = 1'b1;
        i_redirect_pc = r;
        @(negedge i_clk);
        i_redirect = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== r) begin
            errors++; $display("FAIL rap_next valid=%b req=%b addr=%h want 0/1/%h", o_valid, o_imem_req, o_imem_addr, r);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== r || o_instr !== (r ^ KEY)) begin
            errors++; $display("FAIL rap_first valid=%b pc=%h want 1/%h", o_valid, o_pc, r);
        end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0; lat = 0;
        do_reset();
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== INIT) begin
            errors++; $display("FAIL rmid_pre valid=%b pc=%h want 1/%h", o_valid, o_pc, INIT);
        end
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_imem_req !== 1'b0) begin
            errors++; $display("FAIL rmid_rst valid=%b req=%b want 0/0", o_valid, o_imem_req);
        end
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== INIT) begin
            errors++; $display("FAIL rmid_restart valid=%b req=%b addr=%h want 0/1/%h", o_valid, o_imem_req, o_imem_addr, INIT);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== INIT) begin
            errors++; $display("FAIL rmid_first valid=%b pc=%h want 1/%h", o_valid, o_pc, INIT);
        end
    endtask

    // Random ready/redirect/latency/stray acks; decoder must see an unbroken
    // PC stream restarting at each redirect target, with stable handshakes.
    task automatic test_random();
        logic [31:0] exp_pc, prev_addr, rpc;
        bit prev_req, redir_prev, rdy, redir;
        int pops;
        lat = 0; i_ready = 1'b0;
        do_reset();
        rand_lat = 1; stray_en = 1;
        exp_pc = INIT; prev_req = 0; prev_addr = '0; redir_prev = 0; pops = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge i_clk);
            if (prev_req && !i_imem_ack) begin
                checks++;
                if (o_imem_req !== 1'b1 || o_imem_addr !== prev_addr) begin
                    errors++; $display("FAIL rnd_hold n=%0d req=%b addr=%h want 1/%h", n, o_imem_req, o_imem_addr, prev_addr);
                end
            end
            if (o_imem_req === 1'b1) begin
                checks++;
                if (o_imem_addr[1:0] !== 2'b00) begin
                    errors++; $display("FAIL rnd_align n=%0d addr=%h", n, o_imem_addr);
                end
            end
            if (redir_prev) begin
                checks++;
                if (o_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd_flush n=%0d valid=%b want 0", n, o_valid);
                end
            end
            rdy = ($urandom_range(0, 1) == 1);
            redir = ($urandom_range(0, 24) == 0);
            if (o_valid === 1'b1 && rdy && !redir) begin
                checks++;
                if (o_pc !== exp_pc || o_instr !== (exp_pc ^ KEY)) begin
                    errors++; $display("FAIL rnd_pop n=%0d pc=%h instr=%h want %h", n, o_pc, o_instr, exp_pc);
                    exp_pc = o_pc;
                end
                exp_pc += 32'd4;
                pops++;
            end
            if (redir) begin
                rpc = INIT + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
                exp_pc = rpc & ~32'h3;
                i_redirect_pc = rpc;
            end
            prev_req = o_imem_req;
            prev_addr = o_imem_addr;
            redir_prev = redir;
            i_ready = rdy;
            i_redirect = redir;
        end
        @(negedge i_clk);
        i_redirect = 1'b0;
        rand_lat = 0; stray_en = 0;
        checks++;
        if (pops < 300) begin
            errors++; $display("FAIL rnd_progress pops=%0d want >=300", pops);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_discard(1'b0);
        test_redirect_ack_pop();
        test_redirect_discard(1'b1);
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
